// File: rtl/simple_proc_core_p.sv
// Small multi-cycle processor core: fetch / execute / optional memory cycle,
// with an 8-entry register file, a flag register and a private data memory.
module simple_proc_core_p #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 10,
    parameter int DMEM_AW = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       instr,
    input  logic              instr_vld,
    output logic              instr_req,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              halted,
    output logic              wb_en,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              negative,
    output logic              carry,
    output logic              overflow
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_MOVI = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_LD   = 4'd9;
    localparam logic [3:0] OP_ST   = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_BR   = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd14;
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
    localparam int MSB = DATA_W - 1;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic                z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic [DATA_W-1:0]   regs_q [8];
    logic [DATA_W-1:0]   dmem [2**DMEM_AW];
    logic [DATA_W-1:0]   rdata_q;

    logic [1:0]          cond;
    logic [3:0]          op;
    logic [2:0]          rd, ra, rb;
    logic [6:0]          imm7;
    logic [DATA_W-1:0]   rd_val, ra_val, rb_val, imm_sext, imm_zext;
    logic [PC_W-1:0]     pc_off;
    logic [DMEM_AW-1:0]  mem_addr;
    logic                mem_we;
    logic                cond_ok;

    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c, alu_v, alu_wr, flag_upd;

    assign cond     = ir_q[15:14];
    assign op       = ir_q[13:10];
    assign rd       = ir_q[9:7];
    assign ra       = ir_q[6:4];
    assign rb       = ir_q[3:1];
    assign imm7     = ir_q[6:0];
    assign rd_val   = regs_q[rd];
    assign ra_val   = regs_q[ra];
    assign rb_val   = regs_q[rb];
    assign imm_sext = {{(DATA_W-7){imm7[6]}}, imm7};
    assign imm_zext = {{(DATA_W-7){1'b0}}, imm7};
    assign pc_off   = {{(PC_W-7){imm7[6]}}, imm7};
    assign mem_addr = ra_val[DMEM_AW-1:0];

    always_comb begin
        case (cond)
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = z_q;
            2'b10:   cond_ok = n_q;
            default: cond_ok = c_q;
        endcase
    end

    // SUB carry is "no borrow", i.e. the inverse of the extended subtract's top bit.
    always_comb begin
        sum      = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_wr   = 1'b0;
        flag_upd = 1'b0;
        case (op)
            OP_ADD: begin
                sum      = {1'b0, ra_val} + {1'b0, rb_val};
                alu_res  = sum[MSB:0];
                alu_c    = sum[DATA_W];
                alu_v    = (ra_val[MSB] == rb_val[MSB]) && (alu_res[MSB] != ra_val[MSB]);
                alu_wr   = 1'b1;
                flag_upd = 1'b1;
            end
            OP_SUB: begin
                sum      = {1'b0, ra_val} - {1'b0, rb_val};
                alu_res  = sum[MSB:0];
                alu_c    = ~sum[DATA_W];
                alu_v    = (ra_val[MSB] != rb_val[MSB]) && (alu_res[MSB] != ra_val[MSB]);
                alu_wr   = 1'b1;
                flag_upd = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                alu_res  = (op == OP_AND) ? (ra_val & rb_val) :
                           (op == OP_OR)  ? (ra_val | rb_val) : (ra_val ^ rb_val);
                alu_wr   = 1'b1;
                flag_upd = 1'b1;
            end
            OP_SHL: begin
                alu_res  = {ra_val[MSB-1:0], 1'b0};
                alu_c    = ra_val[MSB];
                alu_wr   = 1'b1;
                flag_upd = 1'b1;
            end
            OP_SHR: begin
                alu_res  = {1'b0, ra_val[MSB:1]};
                alu_c    = ra_val[0];
                alu_wr   = 1'b1;
                flag_upd = 1'b1;
            end
            OP_MOVI: begin
                alu_res  = imm_zext;
                alu_wr   = 1'b1;
            end
            OP_ADDI: begin
                sum      = {1'b0, rd_val} + {1'b0, imm_sext};
                alu_res  = sum[MSB:0];
                alu_c    = sum[DATA_W];
                alu_v    = (rd_val[MSB] == imm_sext[MSB]) && (alu_res[MSB] != rd_val[MSB]);
                alu_wr   = 1'b1;
                flag_upd = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        z_d       = z_q;
        n_d       = n_q;
        c_d       = c_q;
        v_d       = v_q;
        instr_req = 1'b0;
        wb_en     = 1'b0;
        result    = '0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                instr_req = 1'b1;
                if (instr_vld) begin
                    ir_d    = instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_q + PC_ONE;
                if (cond_ok) begin
                    case (op)
                        OP_LD: begin
                            pc_d    = pc_q;
                            state_d = MEM;
                        end
                        OP_ST:   mem_we = 1'b1;
                        OP_JMP:  pc_d = ra_val[PC_W-1:0];
                        OP_BR:   pc_d = pc_q + pc_off;
                        OP_HALT: begin
                            pc_d    = pc_q;
                            state_d = HALT;
                        end
                        default: ;
                    endcase
                    if (alu_wr) begin
                        wb_en  = 1'b1;
                        result = alu_res;
                    end
                    if (flag_upd) begin
                        z_d = (alu_res == '0);
                        n_d = alu_res[MSB];
                        c_d = alu_c;
                        v_d = alu_v;
                    end
                end
            end
            MEM: begin
                wb_en   = 1'b1;
                result  = rdata_q;
                pc_d    = pc_q + PC_ONE;
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else if (wb_en) begin
            regs_q[rd] <= result;
        end
    end

    // Data memory is deliberately not reset; a reset drops state to IDLE so mem_we is low.
    always_ff @(posedge clk) begin
        if (mem_we) dmem[mem_addr] <= rb_val;
        rdata_q <= dmem[mem_addr];
    end

    assign pc       = pc_q;
    assign busy     = (state_q == FETCH) || (state_q == EXEC) || (state_q == MEM);
    assign halted   = (state_q == HALT);
    assign zero     = z_q;
    assign negative = n_q;
    assign carry    = c_q;
    assign overflow = v_q;

endmodule

// File: doc/simple_proc_core_p.md
SIMPLE_PROC_CORE_P -- requirements
Module: simple_proc_core_p

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath/register/data-memory width (legal 8..32).
REQ-002 SHALL have parameter PC_W, default 10, program-counter width.
REQ-003 SHALL have parameter DMEM_AW, default 7, data-memory address width (depth 2**DMEM_AW).
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin execution from PC 0.
- instr  in  16  instruction word.
- instr_vld  in  1  instr valid for the current pc.
- instr_req  out  1  fetch request.
- pc  out  PC_W  fetch address.
- busy  out  1  high outside IDLE/HALT.
- halted  out  1  high in HALT.
- wb_en  out  1  register write this cycle.
- result  out  DATA_W  register write data.
- zero, negative, carry, overflow  out  1 each  flag register Z, N, C, V.

Function
REQ-005 SHALL decode instr as: [15:14] cond (00 always, 01 Z, 10 N, 11 C); [13:10] op; [9:7] rd; [6:4] ra; [3:1] rb; [6:0] imm7.
REQ-006 SHALL implement ops:
- 0 ADD rd=ra+rb; 1 SUB rd=ra-rb; 2 AND; 3 OR; 4 XOR.
- 5 SHL rd=ra<<1; 6 SHR rd=ra>>1 (logical).
- 7 MOVI rd=zext(imm7); 8 ADDI rd=rd+sext(imm7).
- 9 LD rd=dmem[ra[DMEM_AW-1:0]]; 10 ST dmem[ra[DMEM_AW-1:0]]=rb.
- 11 JMP pc=ra[PC_W-1:0]; 12 BR pc=pc+sext(imm7); 13, 15 NOP; 14 HALT.
REQ-007 SHALL contain 8 x DATA_W registers and 2**DMEM_AW x DATA_W data memory, synchronous read and write.
REQ-008 SHALL use FSM states IDLE, FETCH, EXEC, MEM, HALT.
REQ-009 IDLE: start=1 -> pc=0, FETCH; otherwise stay.
REQ-010 FETCH: instr_req=1; on instr_vld=1 capture instr, -> EXEC; instr_vld=0 stalls indefinitely with pc held.
REQ-011 EXEC, one cycle: evaluate cond against flags at entry; if false, no register/flag/memory change, pc=pc+1, -> FETCH.
REQ-012 EXEC, cond true, ops 0-8: write rd (wb_en=1, result=value), pc=pc+1, -> FETCH.
REQ-013 EXEC, cond true, LD: issue read, -> MEM; MEM writes rd with read data (wb_en=1), pc=pc+1, -> FETCH.
REQ-014 EXEC, cond true, ST: write memory, no register write, pc=pc+1, -> FETCH.
REQ-015 EXEC, cond true, JMP/BR: set pc per REQ-006, -> FETCH; BR offset is relative to the branch instruction's own address.
REQ-016 EXEC, cond true, HALT: pc unchanged, -> HALT.
REQ-017 Latency: ALU/ST/JMP/BR/skipped = 1 fetch cycle (min) + 1 EXEC cycle; LD adds 1 MEM cycle.
REQ-018 All pc arithmetic SHALL be modulo 2**PC_W (2**PC_W-1 + 1 -> 0).
REQ-019 Flags update only for executed ops 0-6 and 8; all other ops and skipped instructions leave flags unchanged.
REQ-020 Z = result==0; N = result MSB.
REQ-021 C: ADD/ADDI carry out of bit DATA_W-1; SUB no-borrow (ra>=rb unsigned); SHL ra MSB; SHR ra LSB; logic ops clear C.
REQ-022 V: signed overflow for ADD/SUB/ADDI; cleared by all other flag-updating ops.
REQ-023 wb_en SHALL be high exactly one cycle per register write, else low; result is 0 when wb_en=0.
REQ-024 start SHALL be ignored outside IDLE and HALT.
REQ-025 In HALT, start=1 -> pc=0, FETCH; registers, flags and memory are retained.
REQ-026 busy = state in {FETCH, EXEC, MEM}; halted = state==HALT.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, pc=0, all 8 registers=0, flags=0, instr_req=0, wb_en=0, result=0, busy=0, halted=0.
REQ-028 Data memory contents SHALL NOT be reset; reset mid-instruction aborts it with no pending write.

Verification (DATA_W=16)
REQ-029 MOVI r1,0x7F; ADDI r1,1 -> r1=0x0080, wb_en pulses twice, Z=0 N=0 C=0 V=0.
REQ-030 r1=0x7FFF, r2=1, ADD r3,r1,r2 -> r3=0x8000, N=1, V=1, C=0; SUB r4,r2,r2 -> r4=0, Z=1, C=1.
REQ-031 ST [r0=5]=0x1234 then LD r6,[r0] -> r6=0x1234 on the MEM cycle, EXEC-to-write 2 cycles.
REQ-032 cond=01 instruction with Z=0 -> no wb_en, flags unchanged, pc+1; BR -1 at pc 0 -> pc=2**PC_W-1.
REQ-033 instr_vld held low 5 cycles in FETCH -> pc and instr_req held, no state change; HALT -> halted=1; start -> pc=0, FETCH.
REQ-034 rst asserted during MEM of LD -> immediately IDLE, registers 0, no wb_en.
